// File: rtl/val_error_acc_if.sv
// Handshake/data bundle between the training controller side and val_error_acc.
// fsm_state mirrors the accumulator FSM for checkers and waveform debug.
interface val_error_acc_if #(
  parameter int BITS = 16
);
  logic            VL;
  logic [BITS-1:0] VALID;
  logic            S_Out;
  logic [BITS-1:0] Y;
  logic [BITS-1:0] T;
  logic [BITS-1:0] Error;
  logic            S_Error;
  logic            Busy;
  logic [1:0]      fsm_state;

  // Y/T are qualified by S_Out for one cycle (no back-pressure, one sample per
  // cycle); Error is qualified by the one-cycle S_Error strobe and held between strobes.
  modport master (
    output VL, VALID, S_Out, Y, T,
    input  Error, S_Error, Busy, fsm_state
  );

  modport slave (
    input  VL, VALID, S_Out, Y, T,
    output Error, S_Error, Busy, fsm_state
  );
endinterface

// File: rtl/val_error_acc.sv
// Validation-error accumulator: saturating sum of |Y-T| (or (Y-T)^2 when
// ERR_SQUARED_EN is defined) over VALID samples, reported with an S_Error strobe.
module val_error_acc #(
  parameter int BITS = 16
) (
  input logic           clk,
  input logic           rst_n,
  val_error_acc_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [BITS-1:0] MAX = '1;
  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [BITS-1:0]   acc;
  logic [BITS-1:0]   cnt;
  logic [BITS-1:0]   n;
  logic [BITS-1:0]   error_q;
  logic              s_error_q;

  logic signed [BITS:0] d;
  logic [BITS:0]        e;
  logic [BITS+1:0]      sum;
  logic [BITS-1:0]      acc_nx;
  logic [BITS-1:0]      cnt_nx;
`ifdef ERR_SQUARED_EN
  logic [2*BITS+1:0]    sq;
`endif

  always_comb begin
    // One extra bit keeps Y-T exact for any pair of signed inputs.
    d = $signed({bus.Y[BITS-1], bus.Y}) - $signed({bus.T[BITS-1], bus.T});
`ifdef ERR_SQUARED_EN
    sq = d * d;
    e  = (sq > {{(BITS+2){1'b0}}, MAX}) ? {1'b0, MAX} : sq[BITS:0];
`else
    e  = d[BITS] ? $unsigned(-d) : $unsigned(d);
`endif
    sum    = {2'b00, acc} + {1'b0, e};
    acc_nx = (sum[BITS+1:BITS] != 2'b00) ? MAX : sum[BITS-1:0];
    cnt_nx = cnt + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      n         <= '0;
      error_q   <= '0;
      s_error_q <= 1'b0;
    end else begin
      s_error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.VL) begin
            n   <= bus.VALID;
            acc <= '0;
            cnt <= '0;
            if (bus.VALID == '0) begin
              error_q   <= '0;
              s_error_q <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          // Abort takes priority over a sample arriving on the same edge.
          if (!bus.VL) begin
            state <= IDLE;
          end else if (bus.S_Out) begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            if (cnt_nx == n) begin
              error_q   <= acc_nx;
              s_error_q <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.VL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Error     = error_q;
  assign bus.S_Error   = s_error_q;
  assign bus.Busy      = (state == ACC);
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_val_error_acc.sv
// Directed bench for val_error_acc; expected errors are hand-computed for both
// absolute mode and ERR_SQUARED_EN mode.
module tb_val_error_acc;
  localparam int BITS = 16;

`ifdef ERR_SQUARED_EN
  localparam int EXP_BASIC = 38;     // 9+25+0+4
  localparam int EXP_GAP   = 32;     // 16+16
  localparam int EXP_300   = 65535;  // 90000 saturated
  localparam int EXP_RST   = 9;      // 3*3
`else
  localparam int EXP_BASIC = 10;     // 3+5+0+2
  localparam int EXP_GAP   = 8;      // 4+4
  localparam int EXP_300   = 300;
  localparam int EXP_RST   = 3;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  val_error_acc_if #(.BITS(BITS)) bus ();

  val_error_acc #(.BITS(BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // drivers: inputs change right after a falling edge, outputs are checked there too
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input int y, input int t);
    logic [31:0] yv;
    logic [31:0] tv;
    yv = y;
    tv = t;
    bus.S_Out = 1'b1;
    bus.Y     = yv[BITS-1:0];
    bus.T     = tv[BITS-1:0];
    step();
    bus.S_Out = 1'b0;
  endtask

  task automatic start_pass(input int valid);
    logic [31:0] vv;
    vv = valid;
    bus.VL    = 1'b1;
    bus.VALID = vv[BITS-1:0];
    step();
  endtask

  task automatic end_pass();
    bus.VL = 1'b0;
    step();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.VL    = 1'b0;
    bus.VALID = '0;
    bus.S_Out = 1'b0;
    bus.Y     = '0;
    bus.T     = '0;
    repeat (3) step();

    check("rst_error", bus.Error, 0);
    check("rst_s_error", bus.S_Error, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_state", bus.fsm_state, 0);
    rst_n = 1'b1;
    step();

    // basic sum: d = 3, -5, 0, 2
    start_pass(4);
    check("basic_busy", bus.Busy, 1);
    send(3, 0);
    check("basic_s1_nostrobe", bus.S_Error, 0);
    send(0, 5);
    send(7, 7);
    check("basic_s3_nostrobe", bus.S_Error, 0);
    send(-1, -3);
    check("basic_strobe", bus.S_Error, 1);
    check("basic_error", bus.Error, EXP_BASIC);
    step();
    check("basic_strobe_once", bus.S_Error, 0);
    check("basic_busy_low", bus.Busy, 0);
    send(100, 0);
    check("hold_sout_strobe", bus.S_Error, 0);
    check("hold_sout_error", bus.Error, EXP_BASIC);
    end_pass();

    // S_Out while idle
    send(100, 0);
    check("idle_sout_strobe", bus.S_Error, 0);
    check("idle_sout_busy", bus.Busy, 0);

    // abort after 2 of 4 samples
    start_pass(4);
    send(9, 0);
    send(9, 0);
    bus.VL = 1'b0;
    step();
    check("abort_strobe", bus.S_Error, 0);
    check("abort_busy", bus.Busy, 0);
    check("abort_error", bus.Error, EXP_BASIC);
    step();
    check("abort_error_hold", bus.Error, EXP_BASIC);

    // abort on the same edge as the final sample
    start_pass(4);
    send(1, 0);
    send(1, 0);
    send(1, 0);
    bus.VL = 1'b0;
    send(1, 0);
    check("abort_last_strobe", bus.S_Error, 0);
    check("abort_last_error", bus.Error, EXP_BASIC);
    check("abort_last_busy", bus.Busy, 0);
    step();

    // saturation, positive extreme
    start_pass(3);
    send(32'h7FFF, 32'h8000);
    send(32'h7FFF, 32'h8000);
    send(32'h7FFF, 32'h8000);
    check("sat_pos_strobe", bus.S_Error, 1);
    check("sat_pos_error", bus.Error, 32'hFFFF);
    end_pass();

    // zero-length pass
    start_pass(0);
    check("zero_strobe", bus.S_Error, 1);
    check("zero_error", bus.Error, 0);
    check("zero_busy", bus.Busy, 0);
    step();
    check("zero_strobe_once", bus.S_Error, 0);
    end_pass();

    // saturation, negative extreme
    start_pass(2);
    send(32'h8000, 32'h7FFF);
    send(32'h8000, 32'h7FFF);
    check("sat_neg_strobe", bus.S_Error, 1);
    check("sat_neg_error", bus.Error, 32'hFFFF);
    end_pass();

    // gaps between samples; VALID changes mid-pass must be ignored
    start_pass(2);
    send(5, 1);
    bus.VALID = 16'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_nostrobe", bus.S_Error, 0);
    end
    check("gap_busy", bus.Busy, 1);
    send(1, 5);
    check("gap_strobe", bus.S_Error, 1);
    check("gap_error", bus.Error, EXP_GAP);
    end_pass();

    // single large difference
    start_pass(1);
    send(300, 0);
    check("d300_strobe", bus.S_Error, 1);
    check("d300_error", bus.Error, EXP_300);
    end_pass();

    // reset in the middle of a pass
    start_pass(4);
    send(2, 0);
    send(2, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_error", bus.Error, 0);
    check("midrst_s_error", bus.S_Error, 0);
    check("midrst_busy", bus.Busy, 0);
    step();
    bus.VALID = 16'd1;
    rst_n = 1'b1;
    step();
    check("postrst_busy", bus.Busy, 1);
    send(4, 1);
    check("postrst_strobe", bus.S_Error, 1);
    check("postrst_error", bus.Error, EXP_RST);
    step();
    check("postrst_strobe_once", bus.S_Error, 0);
    end_pass();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/val_error_acc.md
# val_error_acc

Validation-error accumulator for the neural-net training loop. It sits directly upstream of the training control block and produces that block's `Error` and `S_Error` inputs. While the controller holds its validation phase (`VL`), this block sums the per-sample error between network output `Y` and target `T` over `VALID` samples. It then presents the total on `Error` with a one-cycle `S_Error` strobe.

## Interface
Parameters:
- `BITS`, default 16: width of data, counts and error.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `VL`, in, 1: validation phase, driven by the controller.
- `VALID`, in, BITS: samples per validation pass (unsigned).
- `S_Out`, in, 1: sample strobe; `Y` and `T` are valid this cycle.
- `Y`, in, BITS: network output, signed two's complement.
- `T`, in, BITS: target value, signed two's complement.
- `Error`, out, BITS: accumulated error of the last completed pass, unsigned.
- `S_Error`, out, 1: one-cycle strobe marking a new `Error`.
- `Busy`, out, 1: high while accumulating.

## Operation
- Internal state: `acc` (BITS, unsigned), `cnt` (BITS), `n` (BITS, latched `VALID`).
- FSM states: IDLE, ACC, HOLD.
- **IDLE**
  - `VL`=1 → latch `n`=`VALID`, clear `acc` and `cnt`.
  - If `VALID`=0, go to HOLD with `Error`←0 and an `S_Error` pulse.
  - Otherwise go to ACC.
- **ACC** (`Busy`=1)
  - Each edge with `S_Out`=1: d = Y − T computed at BITS+1 signed; e = |d| (BITS+1 unsigned).
  - `acc` ← min(`acc` + e, 2^BITS − 1). The sum is saturating and never wraps.
  - `cnt` ← `cnt` + 1.
  - On the edge accepting sample number `n`: `Error` ← the saturated new sum, `S_Error` ← 1, go to HOLD.
  - `VL`=0 in ACC → abort. Go to IDLE with no `S_Error`; `Error` keeps its previous value. An abort wins over a simultaneous final sample.
- **HOLD**
  - `S_Out` is ignored.
  - `VL`=0 → IDLE. A new pass needs `VL` to fall and rise again.
- `S_Out` is ignored outside ACC.
- `VALID` is sampled only at ACC entry; later changes have no effect on the current pass.
- `Error` changes only together with an `S_Error` pulse.

## Timing
- Reset values: `Error`=0, `S_Error`=0, `Busy`=0, FSM=IDLE, `acc`=0, `cnt`=0.
- Reset is effective immediately and asynchronously. A reset mid-pass discards the pass and emits no `S_Error`.
- IDLE→ACC: `Busy` rises in the cycle after the first edge at which `VL`=1 is seen. The earliest accepted sample is at the following edge.
- Latency: `S_Error` is high for exactly one cycle, immediately after the edge that accepted the last sample.
  - `Error` is valid in that same cycle and holds until the next strobe.
- `VALID`=0: the `S_Error` pulse appears in the cycle after `VL` is seen.
- Throughput: one sample per cycle; back-to-back `S_Out` is supported.

## Configuration
- Macro: `ERR_SQUARED_EN`.
- Defined: e = d·d, computed at 2·(BITS+1) bits and saturated to 2^BITS − 1 before accumulation (squared-error mode).
- Undefined: e = |d| (absolute-error mode).
- Saturation, counting, FSM and timing are identical in both modes.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ACC after 2 of 4 samples → `Error`=0, `S_Error`=0, `Busy`=0 immediately. After release, a new pass starts normally.
- **Basic sum:** `VALID`=4, back-to-back d = 3, −5, 0, 2 → `Error`=10. `S_Error` is a single one-cycle pulse right after the 4th sample edge, then `Busy`=0.
- **Saturation:** `BITS`=16, `VALID`=3, `Y`=0x7FFF, `T`=0x8000 each sample → `Error`=0xFFFF with no wrap. `Y`=0x8000, `T`=0x7FFF also gives 0xFFFF.
- **Abort:** `VALID`=4 with a previous `Error`=10; drop `VL` after 2 samples → no `S_Error`, `Error` stays 10.
  - Drop `VL` on the same edge as the 4th sample → still no strobe.
- **Zero count and gaps:**
  - `VALID`=0 → `Error`=0 with one `S_Error` pulse.
  - `VALID`=2 with `S_Out` gaps of 3 idle cycles → strobe only after the 2nd strobed sample.
  - `S_Out` in IDLE or HOLD has no effect.
- **Squared mode:** with `ERR_SQUARED_EN` defined, d = 3, −5, 0, 2 → `Error`=38.
  - A single d = 300 at `BITS`=16 → 65535 (saturated).
